// File: rtl/core_pkg.sv
// Shared core constants: result-source and forwarding-select encodings, register address width.
package core_pkg;

    localparam int unsigned REG_AW = 5;

    localparam logic [1:0] RESULT_ALU  = 2'b00;
    localparam logic [1:0] RESULT_LOAD = 2'b01;
    localparam logic [1:0] RESULT_PC4  = 2'b10;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/fwd_sel.sv
// Operand forwarding select for one EX source register; MEM beats WB, x0 never forwarded.
module fwd_sel
    import core_pkg::*;
#(
    parameter int unsigned AW = 5
) (
    input  logic [AW-1:0] rs,
    input  logic [AW-1:0] rd_m,
    input  logic          reg_write_m,
    input  logic [AW-1:0] rd_w,
    input  logic          reg_write_w,
    output logic [1:0]    fwd
);

    always_comb begin
        fwd = FWD_RF;
        if (reg_write_m && (rd_m != '0) && (rd_m == rs)) begin
            fwd = FWD_MEM;
        end else if (reg_write_w && (rd_w != '0) && (rd_w == rs)) begin
            fwd = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: MEM/WB destination shadows, forwarding, load-use stall, flushes.
// Optional saturating stall/flush counters are built when HAZARD_PERF_EN is defined.
module hazard_unit
    import core_pkg::*;
#(
    parameter int unsigned REG_AW = core_pkg::REG_AW,
    parameter int unsigned PERF_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic              RegWriteE,
    input  logic [1:0]        ResultSrcE,
    input  logic              PCSrcE,
    output logic              StallF,
    output logic              StallD,
    output logic              FlushD,
    output logic              FlushE,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic [REG_AW-1:0] RdM,
    output logic [REG_AW-1:0] RdW
`ifdef HAZARD_PERF_EN
    ,
    output logic [PERF_W-1:0] stall_cnt,
    output logic [PERF_W-1:0] flush_cnt
`endif
);

    logic [REG_AW-1:0] rd_m_q, rd_w_q;
    logic              reg_write_m_q, reg_write_w_q;
    logic [1:0]        fwd_a, fwd_b;
    logic              lw_stall, lw_stall_eff;

    // Shadows advance every edge; bubbles reach E through FlushE, so no freeze is needed.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_m_q        <= '0;
            rd_w_q        <= '0;
            reg_write_m_q <= 1'b0;
            reg_write_w_q <= 1'b0;
        end else begin
            rd_m_q        <= RdE;
            reg_write_m_q <= RegWriteE;
            rd_w_q        <= rd_m_q;
            reg_write_w_q <= reg_write_m_q;
        end
    end

    assign RdM = rd_m_q;
    assign RdW = rd_w_q;

    fwd_sel #(
        .AW (REG_AW)
    ) u_fwd_a (
        .rs          (Rs1E),
        .rd_m        (rd_m_q),
        .reg_write_m (reg_write_m_q),
        .rd_w        (rd_w_q),
        .reg_write_w (reg_write_w_q),
        .fwd         (fwd_a)
    );

    fwd_sel #(
        .AW (REG_AW)
    ) u_fwd_b (
        .rs          (Rs2E),
        .rd_m        (rd_m_q),
        .reg_write_m (reg_write_m_q),
        .rd_w        (rd_w_q),
        .reg_write_w (reg_write_w_q),
        .fwd         (fwd_b)
    );

    always_comb begin
        lw_stall = (ResultSrcE == RESULT_LOAD) && (RdE != '0) &&
                   ((RdE == Rs1D) || (RdE == Rs2D));
        // A taken branch squashes the dependent instruction, so the stall is dropped.
        lw_stall_eff = lw_stall && !PCSrcE;
    end

    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        FlushD    = 1'b1;
        FlushE    = 1'b1;
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        if (!reset) begin
            StallF    = lw_stall_eff;
            StallD    = lw_stall_eff;
            FlushD    = PCSrcE;
            FlushE    = lw_stall_eff || PCSrcE;
            ForwardAE = fwd_a;
            ForwardBE = fwd_b;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (lw_stall_eff && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + PERF_W'(1);
            end
            if (PCSrcE && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + PERF_W'(1);
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    logic unused_perf_w;
    assign unused_perf_w = (PERF_W != 0);
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: vector table plus multi-cycle stall/reset/counter sequences.
module tb_hazard_unit;

    localparam int unsigned AW = 5;
    localparam int unsigned PW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic          RegWriteE, PCSrcE;
    logic [1:0]    ResultSrcE, ForwardAE, ForwardBE;
    logic          StallF, StallD, FlushD, FlushE;
`ifdef HAZARD_PERF_EN
    logic [PW-1:0] stall_cnt, flush_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_unit #(
        .REG_AW (AW),
        .PERF_W (PW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .Rs1D       (Rs1D),
        .Rs2D       (Rs2D),
        .Rs1E       (Rs1E),
        .Rs2E       (Rs2E),
        .RdE        (RdE),
        .RegWriteE  (RegWriteE),
        .ResultSrcE (ResultSrcE),
        .PCSrcE     (PCSrcE),
        .StallF     (StallF),
        .StallD     (StallD),
        .FlushD     (FlushD),
        .FlushE     (FlushE),
        .ForwardAE  (ForwardAE),
        .ForwardBE  (ForwardBE),
        .RdM        (RdM),
        .RdW        (RdW)
`ifdef HAZARD_PERF_EN
        ,
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
`endif
    );

    typedef struct {
        logic [AW-1:0] rdm;  logic wm;
        logic [AW-1:0] rdw;  logic ww;
        logic [AW-1:0] rs1e; logic [AW-1:0] rs2e;
        logic [AW-1:0] rs1d; logic [AW-1:0] rs2d;
        logic [AW-1:0] rde;  logic rwe; logic [1:0] rsrc; logic pcsrc;
        logic [1:0] fa; logic [1:0] fb;
        logic [3:0] ctl;     // {StallF, StallD, FlushD, FlushE}
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_idle();
        Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0;
        RdE = '0; RegWriteE = 1'b0; ResultSrcE = 2'b00; PCSrcE = 1'b0;
    endtask

    // Two edges: first carries the W value into M, second lands it in W and the M value in M.
    task automatic load_shadow(input logic [AW-1:0] rdm, input logic wm,
                               input logic [AW-1:0] rdw, input logic ww);
        @(negedge clk);
        set_idle();
        RdE = rdw; RegWriteE = ww;
        @(negedge clk);
        RdE = rdm; RegWriteE = wm;
        @(negedge clk);
    endtask

    task automatic set_load_stall(input logic [AW-1:0] rd);
        set_idle();
        RdE = rd; RegWriteE = 1'b1; ResultSrcE = 2'b01; Rs1D = rd;
    endtask

    initial begin
        //          rdm  wm rdw ww rs1e rs2e rs1d rs2d rde rwe rsrc pc  fa  fb  ctl
        vecs[0]  = '{5'd5, 1, 5'd0, 0, 5'd5, 5'd6, 5'd0, 5'd0, 5'd0, 0, 2'd0, 0, 2'd2, 2'd0, 4'b0000};
        vecs[1]  = '{5'd5, 1, 5'd5, 1, 5'd5, 5'd6, 5'd0, 5'd0, 5'd0, 0, 2'd0, 0, 2'd2, 2'd0, 4'b0000};
        vecs[2]  = '{5'd9, 1, 5'd5, 1, 5'd5, 5'd6, 5'd0, 5'd0, 5'd0, 0, 2'd0, 0, 2'd1, 2'd0, 4'b0000};
        vecs[3]  = '{5'd9, 1, 5'd7, 1, 5'd1, 5'd7, 5'd0, 5'd0, 5'd0, 0, 2'd0, 0, 2'd0, 2'd1, 4'b0000};
        vecs[4]  = '{5'd0, 1, 5'd7, 1, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 0, 2'd0, 0, 2'd0, 2'd0, 4'b0000};
        vecs[5]  = '{5'd5, 0, 5'd0, 0, 5'd5, 5'd5, 5'd0, 5'd0, 5'd0, 0, 2'd0, 0, 2'd0, 2'd0, 4'b0000};
        vecs[6]  = '{5'd3, 1, 5'd4, 1, 5'd4, 5'd3, 5'd0, 5'd0, 5'd0, 0, 2'd0, 0, 2'd1, 2'd2, 4'b0000};
        vecs[7]  = '{5'd0, 0, 5'd0, 0, 5'd0, 5'd0, 5'd0, 5'd3, 5'd3, 1, 2'd1, 0, 2'd0, 2'd0, 4'b1101};
        vecs[8]  = '{5'd0, 0, 5'd0, 0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1, 2'd1, 0, 2'd0, 2'd0, 4'b0000};
        vecs[9]  = '{5'd0, 0, 5'd0, 0, 5'd0, 5'd0, 5'd3, 5'd0, 5'd3, 1, 2'd0, 0, 2'd0, 2'd0, 4'b0000};
        vecs[10] = '{5'd0, 0, 5'd0, 0, 5'd0, 5'd0, 5'd3, 5'd0, 5'd3, 1, 2'd2, 0, 2'd0, 2'd0, 4'b0000};
        vecs[11] = '{5'd0, 0, 5'd0, 0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 2'd0, 1, 2'd0, 2'd0, 4'b0011};
        vecs[12] = '{5'd0, 0, 5'd0, 0, 5'd0, 5'd0, 5'd4, 5'd0, 5'd4, 1, 2'd1, 1, 2'd0, 2'd0, 4'b0011};
        vecs[13] = '{5'd0, 0, 5'd0, 0, 5'd0, 5'd0, 5'd4, 5'd0, 5'd4, 1, 2'd1, 0, 2'd0, 2'd0, 4'b1101};
        vecs[14] = '{5'd0, 0, 5'd0, 0, 5'd0, 5'd0, 5'd5, 5'd6, 5'd3, 1, 2'd1, 0, 2'd0, 2'd0, 4'b0000};

        set_idle();
        reset = 1'b1;
        #1;
        check("reset ctl", {StallF, StallD, FlushD, FlushE}, 4'b0011);
        check("reset fwd", {ForwardAE, ForwardBE}, 4'b0000);
        @(negedge clk);
        @(negedge clk);
        check("reset RdM", RdM, 0);
        check("reset RdW", RdW, 0);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            load_shadow(vecs[i].rdm, vecs[i].wm, vecs[i].rdw, vecs[i].ww);
            Rs1E = vecs[i].rs1e; Rs2E = vecs[i].rs2e;
            Rs1D = vecs[i].rs1d; Rs2D = vecs[i].rs2d;
            RdE = vecs[i].rde; RegWriteE = vecs[i].rwe;
            ResultSrcE = vecs[i].rsrc; PCSrcE = vecs[i].pcsrc;
            #1;
            check($sformatf("vec%0d RdM", i), RdM, vecs[i].rdm);
            check($sformatf("vec%0d RdW", i), RdW, vecs[i].rdw);
            check($sformatf("vec%0d ForwardAE", i), ForwardAE, vecs[i].fa);
            check($sformatf("vec%0d ForwardBE", i), ForwardBE, vecs[i].fb);
            check($sformatf("vec%0d ctl", i), {StallF, StallD, FlushD, FlushE}, vecs[i].ctl);
        end

        // Load-use: one bubble, then the consumer forwards from MEM.
        @(negedge clk);
        set_idle();
        RdE = 5'd3; RegWriteE = 1'b1; ResultSrcE = 2'b01; Rs2D = 5'd3;
        #1;
        check("lu stall", {StallF, StallD, FlushD, FlushE}, 4'b1101);
        @(negedge clk);
        set_idle();
        Rs2E = 5'd3;
        #1;
        check("lu next ctl", {StallF, StallD, FlushD, FlushE}, 4'b0000);
        check("lu next RdM", RdM, 3);
        check("lu next ForwardBE", ForwardBE, 2'b10);

        // Dependent load chain: lw x3; lw x4,0(x3); add ..,x4.
        @(negedge clk);
        set_load_stall(5'd3);
        #1;
        check("chain stall1", {StallF, StallD, FlushD, FlushE}, 4'b1101);
        @(negedge clk);
        set_idle();
        Rs1D = 5'd3;
        #1;
        check("chain bubble", {StallF, StallD, FlushD, FlushE}, 4'b0000);
        @(negedge clk);
        set_idle();
        Rs1E = 5'd3; RdE = 5'd4; RegWriteE = 1'b1; ResultSrcE = 2'b01; Rs1D = 5'd4;
        #1;
        check("chain stall2", {StallF, StallD, FlushD, FlushE}, 4'b1101);
        check("chain ForwardAE", ForwardAE, 2'b01);
        @(negedge clk);
        set_idle();
        Rs1E = 5'd4;
        #1;
        check("chain after", {StallF, StallD, FlushD, FlushE}, 4'b0000);
        check("chain after ForwardAE", ForwardAE, 2'b10);

        // Reset asserted during a load-use stall with live forwarding matches.
        @(negedge clk);
        set_idle();
        RdE = 5'd5; RegWriteE = 1'b1;
        @(negedge clk);
        set_load_stall(5'd3);
        Rs1E = 5'd5; Rs2E = 5'd5;
        #1;
        check("pre-reset ForwardAE", ForwardAE, 2'b10);
        reset = 1'b1;
        #1;
        check("mid reset ctl", {StallF, StallD, FlushD, FlushE}, 4'b0011);
        check("mid reset fwd", {ForwardAE, ForwardBE}, 4'b0000);
        @(negedge clk);
        check("mid reset RdM", RdM, 0);
        check("mid reset RdW", RdW, 0);
        reset = 1'b0;
        set_idle();

`ifdef HAZARD_PERF_EN
        @(negedge clk);
        check("cnt reset", {stall_cnt, flush_cnt}, 0);
        for (int i = 0; i < 3; i++) begin
            set_load_stall(5'd3);
            @(negedge clk);
        end
        for (int i = 0; i < 2; i++) begin
            set_idle();
            PCSrcE = 1'b1;
            @(negedge clk);
        end
        set_idle();
        #1;
        check("stall_cnt 3", stall_cnt, 3);
        check("flush_cnt 2", flush_cnt, 2);
        set_load_stall(5'd3);
        PCSrcE = 1'b1;
        @(negedge clk);
        set_idle();
        #1;
        check("both stall_cnt", stall_cnt, 3);
        check("both flush_cnt", flush_cnt, 3);
        for (int i = 0; i < 6; i++) begin
            set_load_stall(5'd3);
            @(negedge clk);
        end
        for (int i = 0; i < 6; i++) begin
            set_idle();
            PCSrcE = 1'b1;
            @(negedge clk);
        end
        set_idle();
        #1;
        check("stall_cnt sat", stall_cnt, 7);
        check("flush_cnt sat", flush_cnt, 7);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("cnt clear", {stall_cnt, flush_cnt}, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
Pipeline hazard controller for the 5-stage RV32 core; it is the control-side counterpart of the ID/EX register.
- Consumes the E-stage fields that ID/EX produces and keeps its own shadow copies of the MEM/WB destinations.
- Drives the ID/EX clr input (FlushE), the IF/ID flush and the fetch/decode stalls.
- Drives the ALU operand forwarding selects used in EX.

Parameters:
- REG_AW, 5, register address width.
- PERF_W, 32, width of the optional performance counters.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- Rs1D  in  REG_AW  rs1 of the instruction in decode
- Rs2D  in  REG_AW  rs2 of the instruction in decode
- Rs1E  in  REG_AW  rs1 of the instruction in execute
- Rs2E  in  REG_AW  rs2 of the instruction in execute
- RdE  in  REG_AW  destination register in execute
- RegWriteE  in  1  execute instruction writes the register file
- ResultSrcE  in  2  execute result source: 00 ALU, 01 load, 10 PC+4
- PCSrcE  in  1  taken branch or jump resolved in execute
- StallF  out  1  hold the PC
- StallD  out  1  hold the IF/ID register
- FlushD  out  1  clear the IF/ID register
- FlushE  out  1  clear ID/EX (wired to id_ex clr)
- ForwardAE  out  2  operand A select: 00 register file, 01 WB result, 10 MEM ALU result
- ForwardBE  out  2  operand B select, same encoding as ForwardAE
- RdM  out  REG_AW  shadow MEM destination
- RdW  out  REG_AW  shadow WB destination
- stall_cnt  out  PERF_W  load-use stall cycles (only with HAZARD_PERF_EN)
- flush_cnt  out  PERF_W  control-flush cycles (only with HAZARD_PERF_EN)

Behaviour:
- Shadow pipeline, updated every posedge:
  - RdM <= RdE and RegWriteM <= RegWriteE; RdW <= RdM and RegWriteW <= RegWriteM.
  - Updates are unconditional; stalls never freeze E, M or W, because bubbles enter E through FlushE.
- Reset: when reset=1 at a posedge, RdM, RdW, RegWriteM, RegWriteW and the counters all become 0.
- Outputs while reset=1: StallF=0, StallD=0, FlushD=1, FlushE=1, ForwardAE=00, ForwardBE=00.
- Forwarding (combinational, evaluated for Rs1E and for Rs2E independently):
  - 10 if RegWriteM and RdM!=0 and RdM==Rs.
  - else 01 if RegWriteW and RdW!=0 and RdW==Rs.
  - else 00.
  - MEM has priority over WB. x0 is never forwarded.
- Load-use detection: lwStall = (ResultSrcE==01) & (RdE!=0) & ((RdE==Rs1D) | (RdE==Rs2D)).
  - When lwStall: StallF=1, StallD=1, FlushE=1. This costs exactly one bubble.
  - The cycle after a stall, the load sits in M. The dependent instruction then enters E and receives forwarding from the MEM path.
- Control hazard: when PCSrcE=1, FlushD=1 and FlushE=1. This costs two squashed instructions.
- Simultaneous lwStall and PCSrcE: the branch wins.
  - FlushD=1, FlushE=1, StallF=0, StallD=0.
  - The load-dependent instruction in D is squashed, so no stall is taken.
- FlushE = lwStall_eff | PCSrcE, where lwStall_eff = lwStall & ~PCSrcE.
- Back-to-back loads with a dependency chain: each stall is a single cycle. No stall state persists, because detection is re-evaluated every cycle.
- Reset mid-stall: all outputs take their reset values in the same cycle. Shadow state is clear at the next edge.

Optional Feature:
- Macro HAZARD_PERF_EN.
- Defined:
  - stall_cnt increments on each cycle with lwStall_eff=1.
  - flush_cnt increments on each cycle with PCSrcE=1.
  - Both saturate at all-ones and clear on reset.
- Undefined: the counter logic and both counter ports are absent.

Decomposition:
- Shared package core_pkg holds:
  - RESULT_ALU=2'b00, RESULT_LOAD=2'b01, RESULT_PC4=2'b10.
  - FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - REG_AW.
- One natural sub-module: fwd_sel. It is purely combinational and is instantiated twice, for operands A and B.

Test Plan:
- add x5 in M (RegWriteM=1, RdM=5) and Rs1E=5 -> ForwardAE=10. Also make x5 the W destination -> ForwardAE still 10 (MEM priority).
- RdW=7 with RegWriteW=1, Rs2E=7, and M not matching -> ForwardBE=01. Repeat with RdM=0, RegWriteM=1 and Rs2E=0 -> ForwardBE=00.
- ResultSrcE=01, RdE=3, Rs2D=3 -> StallF=1, StallD=1, FlushE=1 for exactly one cycle. Next cycle, Rs2E=3 with RdM=3 -> ForwardBE=10.
- PCSrcE=1 while ResultSrcE=01, RdE=4, Rs1D=4 -> FlushD=1, FlushE=1, StallF=0, StallD=0.
- Assert reset during a load-use stall -> FlushD=1, FlushE=1, StallF=0, all forwards 00. Next edge: RdM=0, RdW=0.
- With HAZARD_PERF_EN: 3 load-use stalls and 2 taken branches -> stall_cnt=3, flush_cnt=2. With counters preset to all-ones, further events -> counters hold all-ones.
